// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the sequential multiply/divide unit
`timescale 1ns/1ps
package multdiv_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int LATENCY    = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/abs32.sv
// rtl/abs32.sv - combinational 32-bit conditional two's-complement negate
`timescale 1ns/1ps
module abs32 (
    input  logic [31:0] value_i,
    input  logic        negate_i,
    output logic [31:0] value_o
);

    assign value_o = negate_i ? (~value_i + 32'd1) : value_i;

endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - 33-cycle signed multiply (shift-add) / divide (restoring) unit
`timescale 1ns/1ps
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    import multdiv_pkg::*;

    localparam logic [5:0] ITER_LAST = 6'(ITERATIONS);

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               is_mul_q, is_mul_d;
    logic               neg_q, neg_d;
    logic               div_ovf_q, div_ovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic               start, iterate, finish;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in, signed_low;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_shift, div_next;
    logic [WIDTH-1:0]   final_res;
    logic               final_exc, mul_ovf;

    assign start = ctrl_MULT | ctrl_DIV;

    abs32 u_abs_a (.value_i(data_operandA), .negate_i(data_operandA[WIDTH-1]), .value_o(mag_a_in));
    abs32 u_abs_b (.value_i(data_operandB), .negate_i(data_operandB[WIDTH-1]), .value_o(mag_b_in));
    // Product low word and quotient both end in acc_q[31:0]; one sign fix serves both.
    abs32 u_sign  (.value_i(acc_q[WIDTH-1:0]), .negate_i(neg_q), .value_o(signed_low));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (cnt_q == ITER_LAST) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        data_resultRDY = (state_q == ST_DONE);
        iterate        = (state_q == ST_RUN) && (cnt_q != ITER_LAST) && !start;
        finish         = (state_q == ST_RUN) && (cnt_q == ITER_LAST) && !start;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-2:0], 1'b0};
        div_diff  = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, mag_b_q};
        div_next  = div_diff[WIDTH] ? div_shift
                                    : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    end

    // Range check on the unsigned magnitude: a negative result may reach 2^31, a positive one 2^31-1.
    always_comb begin
        mul_ovf = neg_q ? ((|acc_q[2*WIDTH-1:WIDTH]) | (acc_q[WIDTH-1] & (|acc_q[WIDTH-2:0])))
                        : (|acc_q[2*WIDTH-1:WIDTH-1]);
        final_res = signed_low;
        final_exc = 1'b0;
        if (is_mul_q) begin
            final_exc = mul_ovf;
        end else if (mag_b_q == '0) begin
            final_res = '0;
            final_exc = 1'b1;
        end else if (div_ovf_q) begin
            final_res = {1'b1, {(WIDTH-1){1'b0}}};
            final_exc = 1'b1;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_b_d   = mag_b_q;
        is_mul_d  = is_mul_q;
        neg_d     = neg_q;
        div_ovf_d = div_ovf_q;
        result_d  = result_q;
        exc_d     = exc_q;
        if (start) begin
            cnt_d     = '0;
            acc_d     = {{WIDTH{1'b0}}, mag_a_in};
            mag_b_d   = mag_b_in;
            is_mul_d  = ctrl_MULT;
            neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_ovf_d = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
        end else if (iterate) begin
            cnt_d = cnt_q + 6'd1;
            acc_d = is_mul_q ? mul_next : div_next;
        end else if (finish) begin
            result_d = final_res;
            exc_d    = final_exc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_b_q   <= '0;
            is_mul_q  <= 1'b0;
            neg_q     <= 1'b0;
            div_ovf_q <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_b_q   <= mag_b_d;
            is_mul_q  <= is_mul_d;
            neg_q     <= neg_d;
            div_ovf_q <= div_ovf_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - directed self-checking bench for multdiv_seq
`timescale 1ns/1ps
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives the strobe so it is sampled on the next rising edge (edge 0), then scrambles operands.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (data_resultRDY) break;
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int n;
        start_op(m, d, a, b);
        wait_rdy(n);
        check({tag, "_latency"}, n, multdiv_pkg::LATENCY);
        check({tag, "_result"}, data_result, exp_res);
        check({tag, "_exc"}, data_exception, exp_exc);
        @(posedge clock);
        #1;
        check({tag, "_rdy_pulse"}, data_resultRDY, 1'b0);
    endtask

    initial begin
        int n;
        #12;
        check("reset_result", data_result, 32'h0);
        check("reset_exc", data_exception, 1'b0);
        check("reset_rdy", data_resultRDY, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul_7_m6",    1, 0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        run_op("mul_ovf",     1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_min_1",   1, 0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
        run_op("mul_m5_m5",   1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25,        1'b0);
        run_op("div_m7_2",    0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        run_op("div_by_zero", 0, 1, 32'd5,         32'd0,         32'h0000_0000, 1'b1);
        run_op("div_min_m1",  0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("div_100_m7",  0, 1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        run_op("both_strobes", 1, 1, 32'd6,        32'd3,         32'd18,        1'b0);

        repeat (5) @(posedge clock);
        #1;
        check("hold_result", data_result, 32'd18);
        check("hold_exc", data_exception, 1'b0);

        // Abort: a divide issued on cycle 10 of a running multiply restarts the unit.
        start_op(1, 0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        start_op(0, 1, 32'd100, 32'd10);
        wait_rdy(n);
        check("abort_latency", n + 10, 43);
        check("abort_result", data_result, 32'd10);
        check("abort_exc", data_exception, 1'b0);

        // Reset asserted mid-multiply clears outputs at once, without waiting for a clock edge.
        start_op(1, 0, 32'd7, 32'd9);
        repeat (14) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid_result", data_result, 32'h0);
        check("rst_mid_exc", data_exception, 1'b0);
        check("rst_mid_rdy", data_resultRDY, 1'b0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        run_op("post_rst_2x3", 1, 0, 32'd2, 32'd3, 32'd6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
